// File: rtl/sqrt_unit_arbiter.sv
// Round-robin front end that shares one fixed-latency sqrt pipeline among several requesters
// and steers each result back to the requester that issued it.
`timescale 1ns/1ps

module sqrt_unit_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int PIPE_LATENCY    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_operand,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            sqrt_in,
    input  logic [31:0]            sqrt_result,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_data,
    output logic                   busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    logic [IDW-1:0]          rr_ptr;
    logic [CW-1:0]           outstanding [NUM_REQ];
    logic [PIPE_LATENCY-1:0] tag_valid;
    logic [IDW-1:0]          tag_id [PIPE_LATENCY];

    logic [NUM_REQ-1:0] eligible;
    logic               high_hit;
    logic               low_hit;
    logic [IDW-1:0]     high_pick;
    logic [IDW-1:0]     low_pick;
    logic               accept;
    logic               issue;
    logic [IDW-1:0]     winner;
    logic [31:0]        win_operand;
    logic               out_valid;

    // Two-pass priority search: lowest eligible index at or above rr_ptr wins,
    // otherwise wrap around to the lowest eligible index overall.
    always_comb begin
        high_hit    = 1'b0;
        low_hit     = 1'b0;
        high_pick   = '0;
        low_pick    = '0;
        win_operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding[i] < CW'(MAX_OUTSTANDING));
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                low_hit  = 1'b1;
                low_pick = IDW'(i);
                if (IDW'(i) >= rr_ptr) begin
                    high_hit  = 1'b1;
                    high_pick = IDW'(i);
                end
            end
        end
        accept = high_hit || low_hit;
        winner = high_hit ? high_pick : low_pick;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_operand = req_operand[32*i +: 32];
            end
        end
    end

    assign issue      = accept && !reset;
    assign out_valid  = tag_valid[PIPE_LATENCY-1] && !reset;
    assign req_ready  = issue ? (NUM_REQ'(1) << winner) : '0;
    assign sqrt_in    = issue ? win_operand : 32'h0;
    assign resp_valid = out_valid ? (NUM_REQ'(1) << tag_id[PIPE_LATENCY-1]) : '0;
    assign resp_data  = sqrt_result;
    assign busy       = (|tag_valid) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= '0;
            tag_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            tag_valid[0] <= issue;
            for (int s = 1; s < PIPE_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end
            if (issue) begin
                rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + IDW'(1);
            end
            // Simultaneous issue and response for one requester cancel out.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && !resp_valid[i]) begin
                    outstanding[i] <= outstanding[i] + CW'(1);
                end else if (resp_valid[i] && !req_ready[i]) begin
                    outstanding[i] <= outstanding[i] - CW'(1);
                end
            end
        end
    end

    // IDs only matter where the matching valid bit is set, so they need no reset.
    always_ff @(posedge clock) begin
        tag_id[0] <= winner;
        for (int s = 1; s < PIPE_LATENCY; s++) begin
            tag_id[s] <= tag_id[s-1];
        end
    end

endmodule
